// File: rtl/shiftreg_univ.sv
// shiftreg_univ -- universal shift register with hold, shift right, shift left
// and parallel load, a shift counter and a one-cycle frame strobe raised each
// time WIDTH shifts have been completed.
//
// Build option: define SHIFTREG_ROTATE_EN to let rot=1 turn shifts into
// rotates. Without it the rot port is present but ignored.
module shiftreg_univ #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     sin_r,
  input  logic                     sin_l,
  input  logic                     rot,
  input  logic [WIDTH-1:0]         pin,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic             fill_r, fill_l;
  logic             shift_req;

  // Serial fill bits: external serial inputs, or the opposite end when rotating.
`ifdef SHIFTREG_ROTATE_EN
  assign fill_r = rot ? q_q[0]       : sin_r;
  assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_r     = sin_r;
  assign fill_l     = sin_l;
`endif

  // Next-state logic: data path, shift counter and frame strobe.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (which would infer a latch); frame defaults low so it is a single-cycle strobe.
    q_d       = q_q;
    cnt_d     = cnt_q;
    frame_d   = 1'b0;
    shift_req = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHR: begin
          q_d       = {fill_r, q_q[WIDTH-1:1]};
          shift_req = 1'b1;
        end
        MODE_SHL: begin
          q_d       = {q_q[WIDTH-2:0], fill_l};
          shift_req = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = pin;
          cnt_d = '0;
        end
        MODE_HOLD: ;
      endcase
    end
    // Direction is irrelevant to the count; only the number of shifts matters.
    if (shift_req) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        frame_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (clr) begin
      q_q     <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign q      = q_q;
  assign cnt    = cnt_q;
  assign frame  = frame_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_univ.sv
// tb_shiftreg_univ -- self-checking bench for shiftreg_univ. Two instances
// (WIDTH=4 and WIDTH=8) share control inputs and are compared every cycle
// against an arithmetic reference model, plus directed spot checks.
module tb_shiftreg_univ;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       clr, en, sin_r, sin_l, rot;
  logic [1:0] mode;
  logic [3:0] pin4, q4, dummy4;
  logic [7:0] pin8, q8;
  logic [1:0] cnt4;
  logic [2:0] cnt8;
  logic       sout_r4, sout_l4, frame4, sout_r8, sout_l8, frame8;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    int unsigned q;
    int unsigned cnt;
    bit          frame;
  } st_t;

  st_t m4, m8;

  always #5 clk = ~clk;

  shiftreg_univ #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .rot(rot), .pin(pin4), .q(q4), .sout_r(sout_r4), .sout_l(sout_l4),
    .cnt(cnt4), .frame(frame4)
  );

  shiftreg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .rot(rot), .pin(pin8), .q(q8), .sout_r(sout_r8), .sout_l(sout_l8),
    .cnt(cnt8), .frame(frame8)
  );

`ifdef SHIFTREG_ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  // Reference: the register as an integer, shifts as multiply/divide by two,
  // the counter as the number of shifts modulo w.
  function automatic st_t step(st_t s, int w, bit e, bit [1:0] md, bit sr,
                               bit sl, bit rt, int unsigned p);
    st_t         n = s;
    int unsigned top = 1 << (w - 1);
    int unsigned fill;
    n.frame = 1'b0;
    if (!e || md == M_HOLD) return n;
    if (md == M_LOAD) begin
      n.q   = p;
      n.cnt = 0;
      return n;
    end
    if (md == M_SHR) begin
      fill = (ROT_BUILD && rt) ? (s.q % 2) : sr;
      n.q  = s.q / 2 + fill * top;
    end else begin
      fill = (ROT_BUILD && rt) ? (s.q / top) : sl;
      n.q  = (s.q % top) * 2 + fill;
    end
    n.cnt   = (s.cnt + 1) % w;
    n.frame = (n.cnt == 0);
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " q4"},      32'(q4),      m4.q);
    check({tag, " cnt4"},    32'(cnt4),    m4.cnt);
    check({tag, " frame4"},  32'(frame4),  32'(m4.frame));
    check({tag, " sout_r4"}, 32'(sout_r4), m4.q % 2);
    check({tag, " sout_l4"}, 32'(sout_l4), m4.q / 8);
    check({tag, " q8"},      32'(q8),      m8.q);
    check({tag, " cnt8"},    32'(cnt8),    m8.cnt);
    check({tag, " frame8"},  32'(frame8),  32'(m8.frame));
    check({tag, " sout_r8"}, 32'(sout_r8), m8.q % 2);
    check({tag, " sout_l8"}, 32'(sout_l8), m8.q / 128);
  endtask

  // One rising edge with the currently driven inputs, then compare at +1.
  task automatic tick(string tag);
    @(posedge clk);
    #1;
    if (!clr) begin
      m4 = step(m4, 4, en, mode, sin_r, sin_l, rot, 32'(pin4));
      m8 = step(m8, 8, en, mode, sin_r, sin_l, rot, 32'(pin8));
    end
    check_all(tag);
  endtask

  // Clear pulse between edges; outputs must be zero before any clock edge.
  task automatic pulse_clr(string tag);
    #2;
    clr = 1'b1;
    #1;
    m4 = '{0, 0, 1'b0};
    m8 = '{0, 0, 1'b0};
    check_all(tag);
    #1;
    clr = 1'b0;
  endtask

  task automatic drive(bit e, bit [1:0] md, bit sr, bit sl, bit rt);
    en = e; mode = md; sin_r = sr; sin_l = sl; rot = rt;
  endtask

  initial begin
    int frames8;
    dummy4 = 4'b0;
    clr = 1'b1; pin4 = 4'hA; pin8 = 8'h5A;
    drive(1'b1, M_LOAD, 1'b1, 1'b1, 1'b0);
    m4 = '{0, 0, 1'b0};
    m8 = '{0, 0, 1'b0};
    #1;
    check_all("reset");
    // Edges while clear is held must not load anything.
    tick("clr_held");
    tick("clr_held2");
    #3;
    clr = 1'b0;

    // Four right shifts from reset: 1,1,0,1 -> 1011 with a frame.
    drive(1'b1, M_SHR, 1'b1, 1'b0, 1'b0); tick("shr1");
    tick("shr2");
    sin_r = 1'b0; tick("shr3");
    sin_r = 1'b1; tick("shr4");
    check("shr4 q4 1011", 32'(q4), 32'h0000_000B);
    check("shr4 frame4", 32'(frame4), 32'd1);
    check("shr4 cnt4", 32'(cnt4), 32'd0);
    drive(1'b1, M_HOLD, 1'b0, 1'b0, 1'b0); tick("hold_after_frame");
    check("frame4 one cycle", 32'(frame4), 32'd0);

    // Load then shift left with sin_l=1.
    pin4 = 4'b0110; pin8 = 8'h36;
    drive(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0); tick("load0110");
    drive(1'b1, M_SHL, 1'b0, 1'b1, 1'b0); tick("shl1");
    check("shl1 q4 1101", 32'(q4), 32'h0000_000D);
    tick("shl2");
    check("shl2 cnt4", 32'(cnt4), 32'd2);
    check("shl2 sout_l4", 32'(sout_l4), 32'd1);
    check("shl2 frame4", 32'(frame4), 32'd0);

    // Enable low: nothing moves for three edges.
    pin4 = 4'b1001;
    drive(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0); tick("load1001");
    drive(1'b0, M_SHR, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("en_low");
    check("en_low q4 1001", 32'(q4), 32'h0000_0009);

    // Mid-frame clear with q=1011, cnt=2.
    pin4 = 4'b1100;
    drive(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0); tick("load1100");
    drive(1'b1, M_SHR, 1'b0, 1'b0, 1'b0); tick("pre_clr1");
    sin_r = 1'b1; tick("pre_clr2");
    check("pre_clr q4 1011", 32'(q4), 32'h0000_000B);
    check("pre_clr cnt4", 32'(cnt4), 32'd2);
    pulse_clr("mid_clr");
    drive(1'b1, M_SHR, 1'b1, 1'b0, 1'b0); tick("after_clr");

    // Rotate right with sin_r=1 from 1000.
    pin4 = 4'b1000; pin8 = 8'h80;
    drive(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0); tick("load1000");
    drive(1'b1, M_SHR, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick("rot_r");
    check("rot_r q4", 32'(q4), ROT_BUILD ? 32'h0000_0008 : 32'h0000_000F);
    check("rot_r frame4", 32'(frame4), 32'd1);

    // WIDTH=8: ten continuous right shifts from clear give one frame.
    pulse_clr("clr_w8");
    drive(1'b1, M_SHR, 1'b1, 1'b0, 1'b0);
    frames8 = 0;
    for (int i = 0; i < 10; i++) begin
      sin_r = 1'($urandom);
      tick("w8_run");
      if (frame8 === 1'b1) frames8++;
      check("w8 frame position", 32'(frame8), 32'(i == 7));
    end
    check("w8 frame count", 32'(frames8), 32'd1);
    check("w8 cnt8 end", 32'(cnt8), 32'd2);

    // Randomized run, mostly shifting, with occasional loads and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_clr("rnd_clr");
      end else begin
        en    = ($urandom_range(0, 7) != 0);
        mode  = ($urandom_range(0, 9) == 0) ? M_LOAD : 2'($urandom_range(0, 2));
        sin_r = 1'($urandom);
        sin_l = 1'($urandom);
        rot   = 1'($urandom);
        pin4  = 4'($urandom);
        pin8  = 8'($urandom);
        tick("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
